memory_controller: RTL and testbench
====================================

Name: memory_controller

Overview:
Responder side of the instruction-fetch memory interface, shared with the load/store buffer (LSB). It accepts a PC request from the instruction fetcher, or a load/store request from the LSB. It serialises each request onto the byte-wide RAM/IO bus and returns the assembled 32-bit result with a one-cycle ready pulse. It is the only block that drives mem_a, mem_dout and mem_wr.

Parameters:
ADDR_W, 32, address width
IO_BASE, 32'h0003_0000, lowest address decoded as IO (addresses >= IO_BASE are IO)

Ports:
clk_in  in  1  clock
rst_in  in  1  synchronous active-high reset
rdy_in  in  1  global enable; low = freeze
mem_din  in  8  RAM/IO read byte, valid one cycle after its mem_a
mem_dout  out  8  write byte
mem_a  out  32  byte address
mem_wr  out  1  1 = write, 0 = read
io_buffer_full  in  1  IO output FIFO full
flush  in  1  misprediction clear; aborts an instruction fetch only
if_to_mc_ready  in  1  fetch request valid, held until served
if_to_mc_PC  in  32  fetch address (word aligned)
mc_to_if_ready  out  1  one-cycle pulse: mc_to_if_inst valid
mc_to_if_inst  out  32  little-endian instruction word
lsb_to_mc_ready  in  1  LSB request valid, held until served
lsb_to_mc_wr  in  1  1 = store, 0 = load
lsb_to_mc_len  in  2  00 byte, 01 half, 11 word (10 illegal, treated as word)
lsb_to_mc_addr  in  32  byte address
lsb_to_mc_data  in  32  store data, low bytes used
mc_to_lsb_ready  out  1  one-cycle pulse: load data valid / store done
mc_to_lsb_data  out  32  load data, zero-extended (sign extension is done in the LSB)

Behaviour:
- Reset: state IDLE; all outputs 0; byte counter and assembly register 0.
- States and transitions:
  - IDLE -> LS_READ, LS_WRITE or IF_READ.
  - LS_READ / IF_READ -> DONE when the last byte is captured.
  - LS_WRITE -> DONE when the last byte is written.
  - DONE -> IDLE unconditionally. DONE never samples new requests, so a requester has one cycle to drop its held ready.
- Arbitration, in IDLE only: the LSB has priority over fetch. Address, length, data and write flag are latched at acceptance. Later input changes are ignored.
- Read of N bytes (N = 1, 2 or 4; fetch is always 4):
  - mem_a = A+k for k = 0..N-1 on consecutive cycles, mem_wr = 0.
  - The byte for A+k is sampled from mem_din one cycle later into bits [8k+7:8k].
  - The ready pulse and data appear in the DONE cycle.
  - A word read accepted at edge E0 drives mem_a in cycles 1-4, captures bytes at E2-E5, and pulses ready in cycle 6.
- Write of N bytes:
  - mem_wr = 1, mem_a = A+k, mem_dout = data[8k+7:8k], one byte per cycle.
  - mc_to_lsb_ready pulses in DONE, the cycle after the last byte.
- IO write (A >= IO_BASE): while io_buffer_full = 1, mem_wr = 0 and the byte index does not advance. The write resumes when io_buffer_full = 0.
- Outside active states: mem_wr = 0, mem_a = 0.
- flush:
  - In IF_READ: abort to IDLE next cycle with no mc_to_if_ready pulse.
  - Asserted in IDLE together with if_to_mc_ready: the fetch is not accepted.
  - No effect on LS_READ / LS_WRITE.
  - In DONE for a fetch: the pulse is suppressed.
- rdy_in = 0: no register changes, mem_wr forced 0. The byte whose data was in flight is discarded, and its address is re-issued on the first cycle with rdy_in = 1.
- Address arithmetic wraps modulo 2^32.
- Reset mid-transfer: return to IDLE immediately; no pulse.

Decomposition:
- Shared defines header: state encodings, LEN_BYTE/HALF/WORD codes, IO_BASE, ADDR_TYPE/INST_TYPE widths.
- No sub-module; the byte sequencer is a counter plus shift/assembly register inside this module.

Test Plan:
- Fetch PC=0x1000, RAM 0x1000..0x1003 = 13,05,00,00 -> mem_a 0x1000..0x1003 in cycles 1-4; mc_to_if_inst = 0x00000513, one-cycle pulse in cycle 6.
- Simultaneous fetch 0x2000 and LSB load word 0x3000 -> LSB served first (mc_to_lsb_ready before any mem_a = 0x2000); fetch served right after DONE/IDLE.
- Store half 0xBEEF at 0x10 -> mem_wr = 1 with (0x10, EF), then (0x11, BE); mc_to_lsb_ready next cycle; 0x12 untouched.
- IO store byte 0x41 to 0x30000 with io_buffer_full high 3 cycles -> mem_wr stays 0 for 3 cycles, then a single write of 0x41; ready pulses once.
- flush in cycle 3 of fetch 0x4000 -> no mc_to_if_ready; IDLE by cycle 4; a load byte at 0x8 then completes returning 0x000000XX.
- rdy_in low in cycle 3 of a word load -> no state change while low; on resume the missing byte address is re-issued and the assembled word matches RAM contents.

Source files
------------

// File: rtl/memory_controller_pkg.sv
// Shared constants for the byte-serial memory controller: state codes, access lengths,
// the IO address window and the bus word types.
package memory_controller_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int INST_WIDTH = 32;
  localparam logic [31:0] IO_BASE_DEFAULT = 32'h0003_0000;

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [INST_WIDTH-1:0] inst_t;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LS_READ  = 3'd1;
  localparam logic [2:0] S_LS_WRITE = 3'd2;
  localparam logic [2:0] S_IF_READ  = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;

  localparam logic [1:0] LEN_BYTE = 2'b00;
  localparam logic [1:0] LEN_HALF = 2'b01;
  localparam logic [1:0] LEN_WORD = 2'b11;

  // The unused 2'b10 code falls through to a full word.
  function automatic logic [2:0] len_bytes(input logic [1:0] len);
    case (len)
      LEN_BYTE: return 3'd1;
      LEN_HALF: return 3'd2;
      LEN_WORD: return 3'd4;
      default:  return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/memory_controller_if.sv
// Request/response bundle between the memory controller and its two requesters
// (instruction fetcher and load/store buffer).
interface memory_controller_if #(
  parameter int ADDR_W = memory_controller_pkg::ADDR_WIDTH
);
  import memory_controller_pkg::*;

  logic              if_to_mc_ready;
  logic [ADDR_W-1:0] if_to_mc_PC;
  logic              mc_to_if_ready;
  inst_t             mc_to_if_inst;

  logic              lsb_to_mc_ready;
  logic              lsb_to_mc_wr;
  logic [1:0]        lsb_to_mc_len;
  logic [ADDR_W-1:0] lsb_to_mc_addr;
  logic [31:0]       lsb_to_mc_data;
  logic              mc_to_lsb_ready;
  logic [31:0]       mc_to_lsb_data;

  modport master (
    output if_to_mc_ready, if_to_mc_PC,
    output lsb_to_mc_ready, lsb_to_mc_wr, lsb_to_mc_len, lsb_to_mc_addr, lsb_to_mc_data,
    input  mc_to_if_ready, mc_to_if_inst, mc_to_lsb_ready, mc_to_lsb_data
  );

  modport slave (
    input  if_to_mc_ready, if_to_mc_PC,
    input  lsb_to_mc_ready, lsb_to_mc_wr, lsb_to_mc_len, lsb_to_mc_addr, lsb_to_mc_data,
    output mc_to_if_ready, mc_to_if_inst, mc_to_lsb_ready, mc_to_lsb_data
  );

endinterface

// File: rtl/memory_controller.sv
// Serialises fetch and load/store requests onto the byte-wide RAM/IO bus, LSB first;
// a word read answers 6 cycles after acceptance, rdy_in low freezes, a full IO FIFO stalls writes.
module memory_controller
  import memory_controller_pkg::*;
#(
  parameter int                ADDR_W  = ADDR_WIDTH,
  parameter logic [ADDR_W-1:0] IO_BASE = ADDR_W'(IO_BASE_DEFAULT)
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full,
  input  logic              flush,
  memory_controller_if.slave req
);

  logic [2:0]        state;
  logic [ADDR_W-1:0] addr;
  logic [2:0]        nbytes;
  logic [2:0]        cnt;
  logic              pend;
  logic              held;
  logic              from_if;
  logic [31:0]       buf_q;

  logic [ADDR_W-1:0] cur_a;
  logic [1:0]        cap_idx;
  logic              reading;
  logic              reissue;
  logic              issue;
  logic              capture;
  logic              wr_go;

  // cnt counts bytes already issued; pend marks a read byte whose data arrives this cycle.
  assign cur_a   = addr + ADDR_W'(cnt);
  assign cap_idx = 2'(cnt - 3'd1);
  assign reading = (state == S_LS_READ) || (state == S_IF_READ);
  assign reissue = reading && held && pend;
  assign issue   = reading && !reissue && (cnt < nbytes);
  assign capture = reading && !reissue && pend;
  assign wr_go   = (state == S_LS_WRITE) && !((cur_a >= IO_BASE) && io_buffer_full);

  // Idle and stalled cycles park the bus at address 0 so no IO location is read by accident.
  always_comb begin
    mem_a    = '0;
    mem_wr   = 1'b0;
    mem_dout = 8'h00;
    if (rdy_in) begin
      if (reissue) begin
        mem_a = cur_a - ADDR_W'(1);
      end else if (issue) begin
        mem_a = cur_a;
      end else if (wr_go) begin
        mem_a    = cur_a;
        mem_wr   = 1'b1;
        mem_dout = buf_q[7:0];
      end
    end
  end

  assign req.mc_to_if_ready  = rdy_in && (state == S_DONE) && from_if && !flush;
  assign req.mc_to_lsb_ready = rdy_in && (state == S_DONE) && !from_if;
  assign req.mc_to_if_inst   = buf_q;
  assign req.mc_to_lsb_data  = buf_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state   <= S_IDLE;
      addr    <= '0;
      nbytes  <= 3'd0;
      cnt     <= 3'd0;
      pend    <= 1'b0;
      held    <= 1'b0;
      from_if <= 1'b0;
      buf_q   <= 32'h0;
    end else if (!rdy_in) begin
      held <= 1'b1;
    end else begin
      held <= 1'b0;
      case (state)
        S_IDLE: begin
          cnt  <= 3'd0;
          pend <= 1'b0;
          if (req.lsb_to_mc_ready) begin
            addr    <= req.lsb_to_mc_addr;
            nbytes  <= len_bytes(req.lsb_to_mc_len);
            from_if <= 1'b0;
            buf_q   <= req.lsb_to_mc_wr ? req.lsb_to_mc_data : 32'h0;
            state   <= req.lsb_to_mc_wr ? S_LS_WRITE : S_LS_READ;
          end else if (req.if_to_mc_ready && !flush) begin
            addr    <= req.if_to_mc_PC;
            nbytes  <= 3'd4;
            from_if <= 1'b1;
            buf_q   <= 32'h0;
            state   <= S_IF_READ;
          end
        end
        S_LS_READ, S_IF_READ: begin
          if ((state == S_IF_READ) && flush) begin
            state <= S_IDLE;
          end else if (!reissue) begin
            if (issue) cnt <= cnt + 3'd1;
            pend <= issue;
            if (capture) buf_q[{cap_idx, 3'b000} +: 8] <= mem_din;
            if (capture && (cnt == nbytes)) state <= S_DONE;
          end
        end
        S_LS_WRITE: begin
          if (wr_go) begin
            cnt   <= cnt + 3'd1;
            buf_q <= {8'h00, buf_q[31:8]};
            if (cnt == nbytes - 3'd1) state <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_controller.sv
// Directed scoreboard bench: each test queues the bus cycles and ready pulses it expects,
// and a negedge monitor compares them against the DUT cycle by cycle.
module tb_memory_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        io_full;
  logic        flush;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    int          cyc;
    logic [31:0] a;
    logic        wr;
    logic [7:0]  d;
  } bus_ev_t;

  typedef struct {
    int          cyc;
    logic        is_if;
    logic        chkd;
    logic [31:0] d;
  } rsp_ev_t;

  bus_ev_t    bus_q[$];
  rsp_ev_t    rsp_q[$];
  bus_ev_t    be;
  rsp_ev_t    re;
  logic [7:0] ram [0:65535];
  logic [7:0] io_log[$];

  memory_controller_if bus ();

  memory_controller dut (
    .clk_in         (clk),
    .rst_in         (rst),
    .rdy_in         (rdy),
    .mem_din        (mem_din),
    .mem_dout       (mem_dout),
    .mem_a          (mem_a),
    .mem_wr         (mem_wr),
    .io_buffer_full (io_full),
    .flush          (flush),
    .req            (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM answers one cycle after the address; IO writes are logged instead of stored.
  always @(posedge clk) begin
    if (mem_wr) begin
      if (mem_a < 32'h0003_0000) ram[mem_a[15:0]] = mem_dout;
      else io_log.push_back(mem_dout);
    end
    mem_din <= ram[mem_a[15:0]];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, required %h", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_bus(input int c, input logic [31:0] a, input logic wr, input logic [7:0] d);
    bus_ev_t e;
    e.cyc = c; e.a = a; e.wr = wr; e.d = d;
    bus_q.push_back(e);
  endtask

  task automatic exp_rd(input int c, input logic [31:0] a, input int n);
    for (int i = 0; i < n; i++) exp_bus(c + i, a + 32'(i), 1'b0, 8'h00);
  endtask

  task automatic exp_rsp(input int c, input logic is_if, input logic chkd, input logic [31:0] d);
    rsp_ev_t e;
    e.cyc = c; e.is_if = is_if; e.chkd = chkd; e.d = d;
    rsp_q.push_back(e);
  endtask

  task automatic wait_rsp(input logic is_if, input string name);
    int n;
    n = 0;
    while (n < 40 && !(is_if ? bus.mc_to_if_ready : bus.mc_to_lsb_ready)) begin
      step();
      n++;
    end
    n_chk++;
    if (n >= 40) begin
      n_fail++;
      $display("FAIL %s: no ready pulse within 40 cycles, required one", name);
    end
  endtask

  task automatic lsb_go(input logic wr, input logic [1:0] len, input logic [31:0] a,
                        input logic [31:0] d);
    bus.lsb_to_mc_wr    = wr;
    bus.lsb_to_mc_len   = len;
    bus.lsb_to_mc_addr  = a;
    bus.lsb_to_mc_data  = d;
    bus.lsb_to_mc_ready = 1'b1;
  endtask

  task automatic lsb_done(input string name);
    wait_rsp(1'b0, name);
    bus.lsb_to_mc_ready = 1'b0;
    step();
  endtask

  task automatic if_go(input logic [31:0] pc);
    bus.if_to_mc_PC    = pc;
    bus.if_to_mc_ready = 1'b1;
  endtask

  task automatic if_done(input string name);
    wait_rsp(1'b1, name);
    bus.if_to_mc_ready = 1'b0;
    step();
  endtask

  always @(negedge clk) begin
    while (bus_q.size() > 0 && bus_q[0].cyc < cyc) begin
      be = bus_q.pop_front();
      n_chk++;
      n_fail++;
      $display("FAIL bus_missing: cycle %0d got no access, required addr %h wr %0d", be.cyc, be.a, be.wr);
    end
    if (bus_q.size() > 0 && bus_q[0].cyc == cyc) begin
      be = bus_q.pop_front();
      chk("bus_addr", mem_a, be.a);
      chk("bus_wr", 32'(mem_wr), 32'(be.wr));
      if (be.wr) chk("bus_dout", 32'(mem_dout), 32'(be.d));
    end else if (mem_wr || mem_a != 32'h0) begin
      n_chk++;
      n_fail++;
      $display("FAIL bus_unexpected at cycle %0d: got addr %h wr %0d, required idle bus", cyc, mem_a, mem_wr);
    end

    while (rsp_q.size() > 0 && rsp_q[0].cyc < cyc) begin
      re = rsp_q.pop_front();
      n_chk++;
      n_fail++;
      $display("FAIL rsp_missing: cycle %0d got no pulse, required %s pulse", re.cyc, re.is_if ? "fetch" : "lsb");
    end
    if (rsp_q.size() > 0 && rsp_q[0].cyc == cyc) begin
      re = rsp_q.pop_front();
      chk("rsp_if_pulse", 32'(bus.mc_to_if_ready), 32'(re.is_if));
      chk("rsp_lsb_pulse", 32'(bus.mc_to_lsb_ready), 32'(!re.is_if));
      if (re.chkd) chk("rsp_data", re.is_if ? bus.mc_to_if_inst : bus.mc_to_lsb_data, re.d);
    end else if (bus.mc_to_if_ready || bus.mc_to_lsb_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL rsp_unexpected at cycle %0d: got if=%0d lsb=%0d, required no pulse", cyc, bus.mc_to_if_ready, bus.mc_to_lsb_ready);
    end
  end

  initial begin
    int k;
    rst = 1'b1; rdy = 1'b1; io_full = 1'b0; flush = 1'b0;
    bus.if_to_mc_ready = 1'b0; bus.if_to_mc_PC = 32'h0;
    bus.lsb_to_mc_ready = 1'b0; bus.lsb_to_mc_wr = 1'b0; bus.lsb_to_mc_len = 2'b00;
    bus.lsb_to_mc_addr = 32'h0; bus.lsb_to_mc_data = 32'h0;
    for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
    ram[16'h1000] = 8'h13; ram[16'h1001] = 8'h05;
    ram[16'h2000] = 8'h93; ram[16'h2002] = 8'h10;
    ram[16'h3000] = 8'hDE; ram[16'h3001] = 8'hAD; ram[16'h3002] = 8'hBE; ram[16'h3003] = 8'hEF;
    ram[16'h0500] = 8'h11; ram[16'h0501] = 8'h22; ram[16'h0502] = 8'h33; ram[16'h0503] = 8'h44;
    ram[16'h0008] = 8'hA5; ram[16'h0012] = 8'h77; ram[16'hFFFF] = 8'h5A; ram[16'h0000] = 8'hC3;

    repeat (3) step();
    rst = 1'b0;
    chk("rst_mem_a", mem_a, 32'h0);
    chk("rst_mem_wr", 32'(mem_wr), 32'h0);
    chk("rst_mem_dout", 32'(mem_dout), 32'h0);
    chk("rst_if_ready", 32'(bus.mc_to_if_ready), 32'h0);
    chk("rst_lsb_ready", 32'(bus.mc_to_lsb_ready), 32'h0);
    chk("rst_if_inst", bus.mc_to_if_inst, 32'h0);
    chk("rst_lsb_data", bus.mc_to_lsb_data, 32'h0);
    step();

    // Word fetch: addresses in cycles 1-4, pulse in cycle 6.
    k = cyc;
    if_go(32'h1000);
    exp_rd(k + 1, 32'h1000, 4);
    exp_rsp(k + 6, 1'b1, 1'b1, 32'h0000_0513);
    if_done("fetch_1000");

    // Simultaneous requests: LSB first, fetch two cycles after its DONE.
    k = cyc;
    if_go(32'h2000);
    lsb_go(1'b0, 2'b11, 32'h3000, 32'h0);
    exp_rd(k + 1, 32'h3000, 4);
    exp_rsp(k + 6, 1'b0, 1'b1, 32'hEFBE_ADDE);
    exp_rd(k + 8, 32'h2000, 4);
    exp_rsp(k + 13, 1'b1, 1'b1, 32'h0010_0093);
    lsb_done("arb_lsb");
    if_done("arb_fetch");

    // Store half: only the low two data bytes reach memory.
    k = cyc;
    lsb_go(1'b1, 2'b01, 32'h10, 32'h1234_BEEF);
    exp_bus(k + 1, 32'h10, 1'b1, 8'hEF);
    exp_bus(k + 2, 32'h11, 1'b1, 8'hBE);
    exp_rsp(k + 3, 1'b0, 1'b0, 32'h0);
    lsb_done("store_half");
    chk("ram_10", 32'(ram[16'h0010]), 32'hEF);
    chk("ram_11", 32'(ram[16'h0011]), 32'hBE);
    chk("ram_12_untouched", 32'(ram[16'h0012]), 32'h77);

    // IO store held off for three cycles by a full output FIFO.
    k = cyc;
    io_full = 1'b1;
    lsb_go(1'b1, 2'b00, 32'h0003_0000, 32'h0000_0041);
    repeat (4) step();
    io_full = 1'b0;
    exp_bus(k + 4, 32'h0003_0000, 1'b1, 8'h41);
    exp_rsp(k + 5, 1'b0, 1'b0, 32'h0);
    lsb_done("io_store");
    chk("io_write_count", 32'(io_log.size()), 32'd1);
    if (io_log.size() > 0) chk("io_write_data", 32'(io_log[0]), 32'h41);

    // Flush in cycle 3 aborts the fetch; a byte load follows from IDLE.
    k = cyc;
    if_go(32'h4000);
    exp_rd(k + 1, 32'h4000, 3);
    repeat (3) step();
    flush = 1'b1;
    bus.if_to_mc_ready = 1'b0;
    step();
    flush = 1'b0;
    lsb_go(1'b0, 2'b00, 32'h8, 32'h0);
    exp_rd(k + 5, 32'h8, 1);
    exp_rsp(k + 7, 1'b0, 1'b1, 32'h0000_00A5);
    lsb_done("flush_then_load");

    // rdy_in low for cycles 3-4 of a word load; byte 1 is re-issued on resume.
    k = cyc;
    lsb_go(1'b0, 2'b11, 32'h500, 32'h0);
    exp_rd(k + 1, 32'h500, 2);
    exp_rd(k + 5, 32'h501, 3);
    exp_rsp(k + 9, 1'b0, 1'b1, 32'h4433_2211);
    repeat (3) step();
    rdy = 1'b0;
    repeat (2) step();
    rdy = 1'b1;
    lsb_done("rdy_stall");

    // Half load is zero-extended.
    k = cyc;
    lsb_go(1'b0, 2'b01, 32'h502, 32'h0);
    exp_rd(k + 1, 32'h502, 2);
    exp_rsp(k + 4, 1'b0, 1'b1, 32'h0000_4433);
    lsb_done("load_half");

    // Length code 2'b10 behaves as a word.
    k = cyc;
    lsb_go(1'b0, 2'b10, 32'h1000, 32'h0);
    exp_rd(k + 1, 32'h1000, 4);
    exp_rsp(k + 6, 1'b0, 1'b1, 32'h0000_0513);
    lsb_done("load_len10");

    // Reset in cycle 2 of a fetch: back to IDLE, no pulse.
    k = cyc;
    if_go(32'h600);
    exp_rd(k + 1, 32'h600, 2);
    repeat (2) step();
    rst = 1'b1;
    bus.if_to_mc_ready = 1'b0;
    step();
    rst = 1'b0;
    chk("midrst_mem_a", mem_a, 32'h0);
    chk("midrst_if_ready", 32'(bus.mc_to_if_ready), 32'h0);
    repeat (8) step();

    // Half load across the top of the address space wraps to 0.
    k = cyc;
    lsb_go(1'b0, 2'b01, 32'hFFFF_FFFF, 32'h0);
    exp_rd(k + 1, 32'hFFFF_FFFF, 2);
    exp_rsp(k + 4, 1'b0, 1'b1, 32'h0000_C35A);
    lsb_done("load_wrap");

    repeat (5) step();
    chk("bus_q_drained", 32'(bus_q.size()), 32'd0);
    chk("rsp_q_drained", 32'(rsp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
